// File: rtl/sad_frame_engine_if.sv
// Bundle between the SAD engine, the two row-buffer RAMs and the controlling host.
// The engine side uses the slave modport; the RAM/host environment uses master.
interface sad_frame_engine_if #(
   parameter int ROW_W  = 640,
   parameter int ADDR_W = 9,
   parameter int RSAD_W = 10,
   parameter int SAD_W  = 19
);
   logic              start;
   logic              ram_full_a;
   logic              ram_full_b;
   logic [ROW_W-1:0]  row_a;
   logic [ROW_W-1:0]  row_b;
   logic [ADDR_W-1:0] readAddr;
   logic              busy;
   logic              row_valid;
   logic [RSAD_W-1:0] row_sad;
   logic [ADDR_W-1:0] row_idx;
   logic              done;
   logic [SAD_W-1:0]  sad;
   logic [2:0]        dbg_state;

   // start is a level request sampled only in IDLE; row_valid/done are single-cycle
   // pulses with no back-pressure, and row_a/row_b follow readAddr by one cycle.
   modport master (
      output start, ram_full_a, ram_full_b, row_a, row_b,
      input  readAddr, busy, row_valid, row_sad, row_idx, done, sad, dbg_state
   );

   modport slave (
      input  start, ram_full_a, ram_full_b, row_a, row_b,
      output readAddr, busy, row_valid, row_sad, row_idx, done, sad, dbg_state
   );
endinterface

// File: rtl/sad_frame_engine.sv
// Binary-frame SAD engine: reads both row buffers row by row, XORs each pair and
// accumulates the popcount one SEG_W-wide segment per cycle into row and frame totals.
module sad_frame_engine #(
   parameter int ROW_W  = 640,
   parameter int ROWS   = 480,
   parameter int ADDR_W = 9,
   parameter int SEG_W  = 64,
   parameter int RSAD_W = 10,
   parameter int SAD_W  = 19
) (
   input logic                clk,
   input logic                rst,
   sad_frame_engine_if.slave  bus
);

   localparam int NSEG = ROW_W / SEG_W;
   localparam int S_W  = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int PC_W = $clog2(SEG_W + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_CAPT = 3'd2,
      S_SUM  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] r_q, r_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [S_W-1:0]    s_q, s_d;
   logic [ROW_W-1:0]  diff_q, diff_d;
   logic [RSAD_W-1:0] racc_q, racc_d;
   logic [SAD_W-1:0]  sad_q, sad_d;
   logic [RSAD_W-1:0] row_sad_q, row_sad_d;
   logic [ADDR_W-1:0] row_idx_q, row_idx_d;
   logic              row_valid_q, row_valid_d;

   logic [SEG_W-1:0]  seg;
   logic [PC_W-1:0]   seg_pop;
   logic [RSAD_W-1:0] row_tot;
   logic              last_seg;

   function automatic logic [PC_W-1:0] popcount(input logic [SEG_W-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < SEG_W; i++) c = c + PC_W'(v[i]);
      return c;
   endfunction

   always_comb begin
      seg      = diff_q[s_q*SEG_W +: SEG_W];
      seg_pop  = popcount(seg);
      row_tot  = racc_q + RSAD_W'(seg_pop);
      last_seg = (s_q == S_W'(NSEG - 1));
   end

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      addr_d      = addr_q;
      s_d         = s_q;
      diff_d      = diff_q;
      racc_d      = racc_q;
      sad_d       = sad_q;
      row_sad_d   = row_sad_q;
      row_idx_d   = row_idx_q;
      row_valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Full flags matter only here; dropping them mid-run does not abort.
            if (bus.start && bus.ram_full_a && bus.ram_full_b) begin
               r_d     = '0;
               addr_d  = '0;
               sad_d   = '0;
               racc_d  = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: state_d = S_CAPT;
         S_CAPT: begin
            diff_d  = bus.row_a ^ bus.row_b;
            s_d     = '0;
            racc_d  = '0;
            state_d = S_SUM;
         end
         S_SUM: begin
            racc_d = row_tot;
            s_d    = s_q + S_W'(1);
            if (last_seg) begin
               s_d         = '0;
               row_sad_d   = row_tot;
               row_idx_d   = r_q;
               row_valid_d = 1'b1;
               sad_d       = sad_q + SAD_W'(row_tot);
               if (r_q == ADDR_W'(ROWS - 1)) begin
                  state_d = S_DONE;
               end else begin
                  r_d     = r_q + ADDR_W'(1);
                  addr_d  = r_q + ADDR_W'(1);
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         r_q         <= '0;
         addr_q      <= '0;
         s_q         <= '0;
         diff_q      <= '0;
         racc_q      <= '0;
         sad_q       <= '0;
         row_sad_q   <= '0;
         row_idx_q   <= '0;
         row_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         addr_q      <= addr_d;
         s_q         <= s_d;
         diff_q      <= diff_d;
         racc_q      <= racc_d;
         sad_q       <= sad_d;
         row_sad_q   <= row_sad_d;
         row_idx_q   <= row_idx_d;
         row_valid_q <= row_valid_d;
      end
   end

   assign bus.readAddr  = addr_q;
   assign bus.busy      = (state_q == S_LOAD) || (state_q == S_CAPT) || (state_q == S_SUM);
   assign bus.done      = (state_q == S_DONE);
   assign bus.row_valid = row_valid_q;
   assign bus.row_sad   = row_sad_q;
   assign bus.row_idx   = row_idx_q;
   assign bus.sad       = sad_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sad_frame_engine.sv
// Bench for sad_frame_engine: behavioural RAM pair, per-row SAD scoreboard from
// $countones over the stored frames, and directed scenarios around start/reset.
module tb_sad_frame_engine;
   localparam int ROW_W  = 640;
   localparam int ROWS   = 480;
   localparam int ADDR_W = 9;
   localparam int SEG_W  = 64;
   localparam int RSAD_W = 10;
   localparam int SAD_W  = 19;
   localparam int CPR    = 2 + ROW_W / SEG_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sad_frame_engine_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W), .RSAD_W(RSAD_W), .SAD_W(SAD_W)) bus ();

   sad_frame_engine #(
      .ROW_W(ROW_W), .ROWS(ROWS), .ADDR_W(ADDR_W),
      .SEG_W(SEG_W), .RSAD_W(RSAD_W), .SAD_W(SAD_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [ROW_W-1:0] mem_a [ROWS];
   logic [ROW_W-1:0] mem_b [ROWS];

   // Row-buffer RAMs with one-cycle registered read.
   always @(posedge clk) begin
      bus.row_a <= mem_a[bus.readAddr];
      bus.row_b <= mem_b[bus.readAddr];
   end

   int                checks = 0;
   int                failures = 0;
   logic [RSAD_W-1:0] exp_q[$];
   int                exp_idx;
   logic [SAD_W-1:0]  exp_sad;
   int                prev_addr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [ROW_W-1:0] rand_row();
      logic [ROW_W-1:0] v;
      for (int w = 0; w < ROW_W / 32; w++) v[w*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic build_model();
      int rs;
      exp_q.delete();
      exp_sad = '0;
      exp_idx = 0;
      for (int i = 0; i < ROWS; i++) begin
         rs = $countones(mem_a[i] ^ mem_b[i]);
         exp_q.push_back(RSAD_W'(rs));
         exp_sad = exp_sad + SAD_W'(rs);
      end
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < ROWS; i++) begin
         case (mode)
            0: begin mem_a[i] = rand_row(); mem_b[i] = mem_a[i]; end
            1: begin mem_a[i] = '0; mem_b[i] = '1; end
            2: begin mem_a[i] = '0; mem_b[i] = '0; end
            default: begin
               mem_a[i] = rand_row();
               if ($urandom_range(0, 7) == 0) mem_b[i] = rand_row();
               else mem_b[i] = mem_a[i] ^ (rand_row() & rand_row() & rand_row());
            end
         endcase
      end
      if (mode == 2) begin
         mem_b[0][0]              = 1'b1;
         mem_b[ROWS-1][ROW_W-1]   = 1'b1;
      end
      build_model();
   endtask

   task automatic check_reset_vals();
      chk("rst_readAddr", bus.readAddr, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_row_valid", bus.row_valid, 0);
      chk("rst_row_sad", bus.row_sad, 0);
      chk("rst_row_idx", bus.row_idx, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sad", bus.sad, 0);
   endtask

   task automatic check_row_events();
      logic [RSAD_W-1:0] rs;
      if (bus.row_valid) begin
         if (exp_q.size() == 0) begin
            chk("row_extra", 1, 0);
         end else begin
            rs = exp_q.pop_front();
            chk("row_sad", bus.row_sad, rs);
            chk("row_idx", bus.row_idx, exp_idx);
            exp_idx++;
         end
      end
      if (int'(bus.readAddr) != prev_addr) begin
         if (bus.readAddr != 0) chk("addr_step", bus.readAddr, prev_addr + 1);
         prev_addr = int'(bus.readAddr);
      end
   endtask

   // mode 0: plain run; 1: start pulses and full-flag drop mid-run; 2: reset during row 100
   task automatic run_frame(input int mode);
      int n;
      bit got_done;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.ram_full_a = 1'b1;
      bus.ram_full_b = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      prev_addr = 0;
      n = 0;
      got_done = 1'b0;
      chk("busy_rise", bus.busy, 1);
      check_row_events();
      while (!got_done && n < 6500) begin
         bus.start = (mode == 1 && (n % 997) == 13);
         if (mode == 1 && n == 3000) bus.ram_full_a = 1'b0;
         if (mode == 2 && n == 100 * CPR + 5) begin
            rst = 1'b0;
            @(negedge clk);
            check_reset_vals();
            rst = 1'b1;
            exp_q.delete();
            return;
         end
         @(negedge clk);
         n++;
         check_row_events();
         if (bus.done) got_done = 1'b1;
      end
      bus.start      = 1'b0;
      bus.ram_full_a = 1'b1;
      chk("done_edge", n, CPR * ROWS);
      chk("sad", bus.sad, exp_sad);
      chk("busy_at_done", bus.busy, 0);
      chk("rows_left", exp_q.size(), 0);
      chk("last_addr", bus.readAddr, ROWS - 1);
      @(negedge clk);
      chk("done_pulse", bus.done, 0);
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.ram_full_a = 1'b0;
      bus.ram_full_b = 1'b0;
      for (int i = 0; i < ROWS; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals();
      rst = 1'b1;

      fill(0);
      run_frame(0);
      fill(1);
      run_frame(0);
      fill(2);
      run_frame(0);

      // Start with candidate buffer not full must be ignored.
      bus.ram_full_a = 1'b1;
      bus.ram_full_b = 1'b0;
      bus.start      = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("gate_busy", bus.busy, 0);
         chk("gate_done", bus.done, 0);
      end
      bus.start = 1'b0;
      chk("gate_sad", bus.sad, exp_sad);
      bus.ram_full_b = 1'b1;

      fill(3);
      run_frame(1);

      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         chk("hold_sad", bus.sad, exp_sad);
      end

      fill(3);
      run_frame(2);
      build_model();
      run_frame(0);

      fill(3);
      run_frame(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
